minipit_programmer: RTL and testbench

//   Host-side bus master for the minipit timer configuration port. Serialises a requested

---
 rtl/minipit_programmer.sv | 195 +++++++++++++++++++
 tb/tb_minipit_programmer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minipit_programmer.sv
// Host-side bus master for the minipit timer configuration port.
// Writes divider/repeat, count high byte and count low byte over a
// we/addr/data port, then arms and watches the timer's irq line with
// a down-counting watchdog.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for start; bus quiet
// S_WR_CTRL | writing {divider, repeating, 6'b0} to address 00
// S_WR_HI   | writing count[15:8] to address 01
// S_WR_LO   | writing count[7:0] to address 10
// S_ARMED   | timer running; counting irq edges, watchdog active
// S_DONE    | one-cycle done pulse after a single-shot irq
module minipit_programmer #(
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cfg_divider,
  input  logic        cfg_repeating,
  input  logic [15:0] cfg_count,
  input  logic        abort,
  input  logic        irq_in,
  output logic        bus_we,
  output logic [1:0]  bus_addr,
  output logic [7:0]  bus_data,
  output logic        busy,
  output logic        armed,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  irq_count
);

  // Each write slot lasts HOLD_CYCLES enable cycles plus one gap cycle.
  localparam int unsigned     PH_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_HOLD = PH_W'(HOLD_CYCLES);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [TO_W-1:0] WD_LOAD = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);
  localparam logic            WD_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CTRL = 3'd1,
    S_WR_HI   = 3'd2,
    S_WR_LO   = 3'd3,
    S_ARMED   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic [PH_W-1:0] ph, ph_nx;
  logic [TO_W-1:0] wd, wd_nx;
  logic            sh_div, sh_div_nx;
  logic            sh_rep, sh_rep_nx;
  logic [15:0]     sh_count, sh_count_nx;
  logic [7:0]      irq_count_nx;
  logic            irq_prev;
  logic            irq_edge;
  logic            timeout_nx;
  logic            bus_we_nx;
  logic [1:0]      bus_addr_nx;
  logic [7:0]      bus_data_nx;

  assign irq_edge = irq_in & ~irq_prev;

  // Next-state, shadow/watchdog/counter updates and next registered outputs.
  always_comb begin
    state_nx     = state;
    ph_nx        = ph;
    wd_nx        = wd;
    sh_div_nx    = sh_div;
    sh_rep_nx    = sh_rep;
    sh_count_nx  = sh_count;
    irq_count_nx = irq_count;
    timeout_nx   = 1'b0;

    if ((state != S_IDLE) && abort) begin
      state_nx = S_IDLE;
      ph_nx    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sh_div_nx    = cfg_divider;
            sh_rep_nx    = cfg_repeating;
            sh_count_nx  = cfg_count;
            irq_count_nx = 8'd0;
            ph_nx        = '0;
            state_nx     = S_WR_CTRL;
          end
        end
        S_WR_CTRL, S_WR_HI, S_WR_LO: begin
          if (ph == PH_HOLD) begin
            ph_nx = '0;
            if (state == S_WR_CTRL) begin
              state_nx = S_WR_HI;
            end else if (state == S_WR_HI) begin
              state_nx = S_WR_LO;
            end else begin
              state_nx = S_ARMED;
              wd_nx    = WD_LOAD;
            end
          end else begin
            ph_nx = ph + PH_ONE;
          end
        end
        S_ARMED: begin
          // An irq edge outranks a watchdog expiry in the same cycle.
          if (irq_edge) begin
            if (irq_count != 8'hFF) irq_count_nx = irq_count + 8'd1;
            if (sh_rep) wd_nx = WD_LOAD;
            else        state_nx = S_DONE;
          end else if (WD_EN) begin
            wd_nx = wd - WD_ONE;
            if (wd == WD_ONE) begin
              timeout_nx = 1'b1;
              state_nx   = S_IDLE;
            end
          end
        end
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end

    // Bus outputs follow the upcoming state so they are registered with it.
    bus_we_nx   = 1'b0;
    bus_addr_nx = 2'b00;
    bus_data_nx = 8'h00;
    unique case (state_nx)
      S_WR_CTRL: begin
        bus_we_nx   = (ph_nx < PH_HOLD);
        bus_addr_nx = 2'b00;
        bus_data_nx = {sh_div_nx, sh_rep_nx, 6'b000000};
      end
      S_WR_HI: begin
        bus_we_nx   = (ph_nx < PH_HOLD);
        bus_addr_nx = 2'b01;
        bus_data_nx = sh_count_nx[15:8];
      end
      S_WR_LO: begin
        bus_we_nx   = (ph_nx < PH_HOLD);
        bus_addr_nx = 2'b10;
        bus_data_nx = sh_count_nx[7:0];
      end
      default: begin
        bus_we_nx   = 1'b0;
        bus_addr_nx = 2'b00;
        bus_data_nx = 8'h00;
      end
    endcase
  end

  // State, shadow registers, watchdog and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ph        <= '0;
      wd        <= '0;
      sh_div    <= 1'b0;
      sh_rep    <= 1'b0;
      sh_count  <= 16'h0000;
      irq_prev  <= 1'b0;
      irq_count <= 8'd0;
      bus_we    <= 1'b0;
      bus_addr  <= 2'b00;
      bus_data  <= 8'h00;
      busy      <= 1'b0;
      armed     <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ph        <= ph_nx;
      wd        <= wd_nx;
      sh_div    <= sh_div_nx;
      sh_rep    <= sh_rep_nx;
      sh_count  <= sh_count_nx;
      irq_prev  <= irq_in;
      irq_count <= irq_count_nx;
      bus_we    <= bus_we_nx;
      bus_addr  <= bus_addr_nx;
      bus_data  <= bus_data_nx;
      busy      <= (state_nx != S_IDLE);
      armed     <= (state_nx == S_ARMED);
      done      <= (state_nx == S_DONE);
      timeout   <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_minipit_programmer.sv
// Bench for minipit_programmer: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_minipit_programmer;

  localparam int HOLD = 2;
  localparam int TO   = 20;
  localparam int SLOT = HOLD + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_divider = 1'b0;
  logic        cfg_repeating = 1'b0;
  logic [15:0] cfg_count = 16'h0000;
  logic        abort = 1'b0;
  logic        irq_in = 1'b0;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        busy, armed, done, timeout;
  logic [7:0]  irq_count;
  logic [22:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  minipit_programmer #(
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TO),
    .TO_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_divider(cfg_divider),
    .cfg_repeating(cfg_repeating),
    .cfg_count(cfg_count),
    .abort(abort),
    .irq_in(irq_in),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_data(bus_data),
    .busy(busy),
    .armed(armed),
    .done(done),
    .timeout(timeout),
    .irq_count(irq_count)
  );

  assign dut_vec = {bus_we, bus_addr, bus_data, busy, armed, done, timeout, irq_count};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 writing, 2 armed, 3 done.
  // m_t counts cycles since the accepted start; m_age counts armed cycles
  // since entry or since the last irq edge.
  int          m_mode, m_t, m_age, m_irqs;
  bit          m_div, m_rep, m_prev;
  bit [15:0]   m_cnt;
  logic [22:0] exp_vec = '0;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_age = 0; m_irqs = 0;
    m_div = 0; m_rep = 0; m_prev = 0; m_cnt = 0;
    exp_vec = '0;
  endtask

  task automatic model_step();
    bit ev, to, we;
    int k, o;
    logic [1:0] addr;
    logic [7:0] data;
    ev = irq_in && !m_prev;
    m_prev = irq_in;
    to = 0;
    case (m_mode)
      0: if (start) begin
           m_div = cfg_divider; m_rep = cfg_repeating; m_cnt = cfg_count;
           m_irqs = 0; m_mode = 1; m_t = 1;
         end
      1: if (abort) m_mode = 0;
         else begin
           m_t++;
           if (m_t == 3 * SLOT + 1) begin m_mode = 2; m_age = 0; end
         end
      2: if (abort) m_mode = 0;
         else if (ev) begin
           if (m_irqs < 255) m_irqs++;
           if (m_rep) m_age = 0; else m_mode = 3;
         end else if (TO != 0) begin
           m_age++;
           if (m_age == TO) begin to = 1; m_mode = 0; end
         end
      default: m_mode = 0;
    endcase
    we = 0; addr = 2'b00; data = 8'h00;
    if (m_mode == 1) begin
      k = (m_t - 1) / SLOT;
      o = (m_t - 1) % SLOT;
      we = (o < HOLD);
      addr = k[1:0];
      data = (k == 0) ? {m_div, m_rep, 6'b0} : (k == 1) ? m_cnt[15:8] : m_cnt[7:0];
    end
    exp_vec = {we, addr, data, (m_mode != 0), (m_mode == 2), (m_mode == 3), to, m_irqs[7:0]};
  endtask

  // Model advances on every active edge with the same inputs the DUT samples.
  initial forever begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Whole-output comparison each cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) check_eq("outs", {9'b0, dut_vec}, {9'b0, exp_vec});
  end

  // ---------------- stimulus helpers ----------------
  task automatic kick_start(input logic d, input logic r, input logic [15:0] c);
    cfg_divider = d; cfg_repeating = r; cfg_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_armed(output int n);
    n = 0;
    while (!armed && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic go_idle();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL global_time_limit got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n, arm_at, drop, dn, tos;
    logic [8:0] we_pat;
    logic [9:0] wr [3];

    repeat (3) @(negedge clk);
    check_eq("reset_outs", {9'b0, dut_vec}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Single-shot programming, write sequence, arm latency, one irq.
    kick_start(1'b1, 1'b0, 16'h1234);
    arm_at = 0;
    we_pat = '0;
    for (int i = 1; i <= 15; i++) begin
      if (i <= 9) we_pat[i-1] = bus_we;
      if (i == 1 || i == 4 || i == 7) wr[(i-1)/3] = {bus_addr, bus_data};
      if (armed && arm_at == 0) arm_at = i;
      if (i == 15) irq_in = 1'b1;
      @(negedge clk);
    end
    irq_in = 1'b0;
    check_eq("we_pattern", {23'b0, we_pat}, 32'h0DB);
    check_eq("wr_ctrl", {22'b0, wr[0]}, 32'h080);
    check_eq("wr_hi", {22'b0, wr[1]}, 32'h112);
    check_eq("wr_lo", {22'b0, wr[2]}, 32'h234);
    check_eq("arm_latency", arm_at, 10);
    check_eq("ss_done", {31'b0, done}, 1);
    check_eq("ss_irq_count", {24'b0, irq_count}, 1);
    @(negedge clk);
    check_eq("ss_idle", {30'b0, busy, done}, 0);

    // Watchdog timeout with no irq.
    kick_start(1'b0, 1'b0, 16'h00FF);
    wait_armed(n);
    check_eq("arm_latency2", n, 9);
    n = 0;
    while (!timeout && n < 40) begin @(negedge clk); n++; end
    check_eq("timeout_delay", n, TO);
    check_eq("timeout_idle", {30'b0, busy, armed}, 0);
    @(negedge clk);
    check_eq("timeout_single", {31'b0, timeout}, 0);

    // Repeating mode, 300 irqs spaced 4 cycles.
    kick_start(1'b0, 1'b1, 16'($urandom));
    wait_armed(n);
    drop = 0; dn = 0;
    for (int p = 0; p < 300; p++) begin
      irq_in = 1'b1;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        irq_in = 1'b0;
        if (!armed) drop++;
        if (done) dn++;
      end
    end
    check_eq("rep_armed_drops", drop, 0);
    check_eq("rep_no_done", dn, 0);
    check_eq("rep_saturate", {24'b0, irq_count}, 255);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("rep_abort_idle", {29'b0, busy, bus_we, done}, 0);
    check_eq("rep_abort_keep", {24'b0, irq_count}, 255);
    @(negedge clk);

    // Abort during WR_HI; start while busy must not re-latch.
    kick_start(1'b0, 1'b1, 16'hA55A);
    cfg_count = 16'hFFFF; cfg_divider = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("no_relatch", {22'b0, bus_addr, bus_data}, 32'h1A5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_we", {31'b0, bus_we}, 0);
    check_eq("abort_busy", {31'b0, busy}, 0);
    dn = 0;
    repeat (5) begin @(negedge clk); if (done || timeout) dn++; end
    check_eq("abort_no_pulse", dn, 0);

    // irq edge on the expiry cycle; irq held 3 cycles counts once.
    kick_start(1'b1, 1'b1, 16'h0042);
    wait_armed(n);
    repeat (19) @(negedge clk);
    irq_in = 1'b1;
    tos = 0;
    repeat (3) begin @(negedge clk); if (timeout) tos++; end
    irq_in = 1'b0;
    check_eq("edge_beats_expiry", tos, 0);
    check_eq("held_irq_once", {24'b0, irq_count}, 1);
    check_eq("still_armed", {31'b0, armed}, 1);
    go_idle();

    // Random traffic with three irq densities.
    for (int blk = 0; blk < 3; blk++) begin
      for (int c = 0; c < 1000; c++) begin
        start         = ($urandom_range(7) == 0);
        cfg_divider   = 1'($urandom);
        cfg_repeating = 1'($urandom);
        cfg_count     = 16'($urandom);
        abort         = ($urandom_range(39) == 0);
        case (blk)
          0:       irq_in = ($urandom_range(5) == 0);
          1:       irq_in = ($urandom_range(39) == 0);
          default: irq_in = 1'b0;
        endcase
        @(negedge clk);
      end
    end
    start = 1'b0; abort = 1'b0; irq_in = 1'b0;
    go_idle();

    // Asynchronous reset in the middle of a write.
    kick_start(1'b1, 1'b1, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_we", {31'b0, bus_we}, 0);
    check_eq("async_rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
